// File: rtl/program_counter_pkg.sv
// Shared RV32 fetch constants: architectural width and boot vector.
// Fetch and branch logic import these so the reset PC is defined in one place.
package program_counter_pkg;

    localparam int unsigned       XLEN         = 32;
    localparam logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Architectural PC register for the fetch stage: loads the next-PC every rising edge,
// returns to the boot vector asynchronously while reset is high.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned       WIDTH       = XLEN,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(RESET_VECTOR),
    parameter bit                FORCE_ALIGN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC_in,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = PC_in;
        if (FORCE_ALIGN) begin
            pc_d[1:0] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_out = pc_q;

`ifndef SYNTHESIS
    // Simulation-only sanity checks on the architectural contract.
    a_reset_holds: assert property (@(posedge clk) reset |-> (PC_out == RESET_VALUE));

    if (FORCE_ALIGN) begin : g_align_chk
        a_word_aligned: assert property (@(posedge clk) disable iff (reset)
                                         (PC_out[1:0] == 2'b00));
    end
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: unaligned and word-aligned instances share PC_in,
// checked each cycle against a time-stamped load/reset model plus literal expectations.
module tb_program_counter;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_out_al;

    int checks = 0;
    int passed = 0;

    program_counter #(
        .WIDTH       (32),
        .RESET_VALUE (RV),
        .FORCE_ALIGN (1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .PC_in  (pc_in),
        .PC_out (pc_out)
    );

    program_counter #(
        .WIDTH       (32),
        .RESET_VALUE (RV),
        .FORCE_ALIGN (1'b1)
    ) dut_al (
        .clk    (clk),
        .reset  (reset),
        .PC_in  (pc_in),
        .PC_out (pc_out_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remember when and what was last loaded, and when reset last rose.
    time         last_load_t   = 0;
    logic [31:0] last_load_val = '0;
    time         last_rise_t   = 0;
    bit          seen_reset    = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            last_load_t   <= $time;
            last_load_val <= pc_in;
        end
    end

    always @(posedge reset) begin
        last_rise_t <= $time;
        seen_reset  <= 1'b1;
    end

    function automatic logic [31:0] exp_pc(input bit align);
        if (reset || (last_rise_t > last_load_t))
            return RV;
        return align ? (last_load_val & 32'hFFFF_FFFC) : last_load_val;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (seen_reset) begin
                check("cycle_pc",    pc_out,    exp_pc(1'b0));
                check("cycle_pc_al", pc_out_al, exp_pc(1'b1));
            end
        end
    end

    initial begin
        reset = 1'b0;
        pc_in = '0;

        #2  reset = 1'b1;
        #1  check("async_reset",      pc_out,    32'h0);
            check("async_reset_al",   pc_out_al, 32'h0);

        #9  reset = 1'b0;
        #5  check("release_no_load",  pc_out,    32'h0);
            check("release_no_load_al", pc_out_al, 32'h0);

        #5  pc_in = 32'h4;
        #5  check("load_4",           pc_out,    32'h4);
            check("load_4_al",        pc_out_al, 32'h4);

        #5  pc_in = 32'h8;
        #5  check("load_8",           pc_out,    32'h8);
            check("load_8_al",        pc_out_al, 32'h8);

        #5  pc_in = 32'hC;
        #5  check("load_c",           pc_out,    32'hC);
            check("load_c_al",        pc_out_al, 32'hC);
            check("model_pin_c",      exp_pc(1'b0), 32'hC);

        #5  reset = 1'b1;
        #1  check("midrun_async_reset", pc_out,    32'h0);
            check("midrun_async_reset_al", pc_out_al, 32'h0);
            check("model_pin_reset",  exp_pc(1'b0), 32'h0);
        #4  check("reset_holds_edge", pc_out,    32'h0);
            check("reset_holds_edge_al", pc_out_al, 32'h0);

        #5  reset = 1'b0;
        #5  check("first_load_after", pc_out,    32'hC);
            check("first_load_after_al", pc_out_al, 32'hC);

        #5  pc_in = 32'h10;
        #5  check("load_10",          pc_out,    32'h10);
            check("load_10_al",       pc_out_al, 32'h10);

        #5  pc_in = 32'h14;
        #4  pc_in = 32'h99;
        #2  pc_in = 32'h14;
        #1  check("glitch_no_effect", pc_out,    32'h14);
            check("glitch_no_effect_al", pc_out_al, 32'h14);
        #8  check("after_glitch_edge", pc_out,   32'h14);
            check("after_glitch_edge_al", pc_out_al, 32'h14);

        pc_in = 32'h0000_0007;
        #10 check("unaligned_raw",    pc_out,    32'h0000_0007);
            check("unaligned_forced", pc_out_al, 32'h0000_0004);

        pc_in = 32'hFFFF_FFFF;
        #10 check("all_ones_raw",     pc_out,    32'hFFFF_FFFF);
            check("all_ones_forced",  pc_out_al, 32'hFFFF_FFFC);
            check("model_pin_align",  exp_pc(1'b1), 32'hFFFF_FFFC);

        #5;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_program_counter
